bsg_fpu_mul_result_buffer: RTL and testbench

//  Output stage directly downstream of the pipelined FP multiplier. Consumes its
//  v/z/flag outputs through the multiplier's yumi protocol and re-presents them on
//  a registered valid/ready interface through a 2-entry FIFO. Maintains sticky

---
 rtl/bsg_fpu_mul_result_buffer.sv | 130 +++++++++++++
 tb/tb_bsg_fpu_mul_result_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_mul_result_buffer.sv
// bsg_fpu_mul_result_buffer
// Output stage behind the pipelined FP multiplier. Results are pulled from the
// multiplier with its yumi handshake and held in a 2-entry FIFO. The FIFO presents
// them downstream on a registered valid/ready port.
// Sticky exception flags are accumulated at enqueue time and can be cleared by
// software.
// Optional feature macro: BSG_FPU_MUL_RESULT_BUFFER_EXC_COUNT_EN adds a saturating
// counter of flagged results on exc_count_o. Without it, exc_count_o is tied to 0.
module bsg_fpu_mul_result_buffer #(
  parameter int e_p         = 8,
  parameter int m_p         = 23,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [e_p+m_p:0]       z_i,
  input  logic [3:0]             flags_i,
  output logic                   yumi_o,
  output logic                   v_o,
  output logic [e_p+m_p:0]       z_o,
  output logic [3:0]             flags_o,
  input  logic                   ready_i,
  input  logic                   clear_flags_i,
  output logic [3:0]             sticky_flags_o,
  output logic [cnt_width_p-1:0] exc_count_o
);

  localparam int width_lp = e_p + m_p + 1;

  logic [width_lp-1:0] z_mem_q     [2];
  logic [width_lp-1:0] z_mem_d     [2];
  logic [3:0]          flags_mem_q [2];
  logic [3:0]          flags_mem_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [3:0]          sticky_q, sticky_d;
  logic                enq, deq;

  // Handshake decode: accept from the multiplier whenever a slot is free (never
  // while in reset), and release the head whenever downstream takes it. yumi_o
  // depends only on v_i and the registered count, never on ready_i.
  always_comb begin
    enq = v_i & ~reset_i & (count_q != 2'd2);
    deq = (count_q != 2'd0) & ready_i;
  end

  // FIFO and sticky-flag next state. The count alone tracks full/empty, so the
  // 1-bit pointers are free to wrap.
  always_comb begin
    z_mem_d     = z_mem_q;
    flags_mem_d = flags_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (enq) begin
      z_mem_d[wr_ptr_q]     = z_i;
      flags_mem_d[wr_ptr_q] = flags_i;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (deq) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    sticky_d = (clear_flags_i ? 4'b0000 : sticky_q) | (enq ? flags_i : 4'b0000);
  end

  // State registers; reset discards any buffered results.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        z_mem_q[i]     <= '0;
        flags_mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= 4'b0000;
    end else begin
      z_mem_q     <= z_mem_d;
      flags_mem_q <= flags_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
    end
  end

  // Head presentation is built purely from registers. Data is forced to zero when
  // empty, so a drained slot never leaks stale data.
  always_comb begin
    v_o            = (count_q != 2'd0);
    z_o            = v_o ? z_mem_q[rd_ptr_q] : '0;
    flags_o        = v_o ? flags_mem_q[rd_ptr_q] : 4'b0000;
    yumi_o         = enq;
    sticky_flags_o = sticky_q;
  end

`ifdef BSG_FPU_MUL_RESULT_BUFFER_EXC_COUNT_EN
  logic [cnt_width_p-1:0] exc_cnt_q, exc_cnt_d;

  // Saturating count of flagged results. A clear and an increment in the same
  // cycle leave the counter at 1.
  always_comb begin
    exc_cnt_d = clear_flags_i ? '0 : exc_cnt_q;
    if (enq && (|flags_i) && (exc_cnt_d != '1)) begin
      exc_cnt_d = exc_cnt_d + cnt_width_p'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      exc_cnt_q <= '0;
    end else begin
      exc_cnt_q <= exc_cnt_d;
    end
  end

  assign exc_count_o = exc_cnt_q;
`else
  assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_fpu_mul_result_buffer.sv
// tb_bsg_fpu_mul_result_buffer
// Table of per-cycle vectors plus hand-written corner sequences. A negedge
// monitor keeps a reference queue, sticky model and counter model, and checks
// every cycle. The counter expectation follows
// BSG_FPU_MUL_RESULT_BUFFER_EXC_COUNT_EN.
module tb_bsg_fpu_mul_result_buffer;

`ifdef BSG_FPU_MUL_RESULT_BUFFER_EXC_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [31:0] z_i;
  logic [3:0]  flags_i;
  logic        yumi_o;
  logic        v_o;
  logic [31:0] z_o;
  logic [3:0]  flags_o;
  logic        ready_i;
  logic        clear_flags_i;
  logic [3:0]  sticky_flags_o;
  logic [1:0]  exc_count_o;

  int checks   = 0;
  int failures = 0;

  bsg_fpu_mul_result_buffer #(.e_p(8), .m_p(23), .cnt_width_p(2)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .v_i            (v_i),
    .z_i            (z_i),
    .flags_i        (flags_i),
    .yumi_o         (yumi_o),
    .v_o            (v_o),
    .z_o            (z_o),
    .flags_o        (flags_o),
    .ready_i        (ready_i),
    .clear_flags_i  (clear_flags_i),
    .sticky_flags_o (sticky_flags_o),
    .exc_count_o    (exc_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic v, input logic [31:0] z, input logic [3:0] f,
                               input logic rdy, input logic clr);
    v_i           = v;
    z_i           = z;
    flags_i       = f;
    ready_i       = rdy;
    clear_flags_i = clr;
  endtask

  // Reference model: scoreboard queue plus sticky and counter models, updated mid-cycle.
  logic [35:0] sb[$];
  logic [35:0] head;
  logic [3:0]  m_st  = 4'b0000;
  logic [1:0]  m_cnt = 2'd0;
  logic        m_yumi;

  always @(negedge clk_i) begin
    if (reset_i) begin
      sb.delete();
      m_st  = 4'b0000;
      m_cnt = 2'd0;
    end else begin
      m_yumi = v_i && (sb.size() < 2);
      checkOutput("mon_yumi_o", 64'(yumi_o), 64'(m_yumi));
      checkOutput("mon_v_o", 64'(v_o), 64'(sb.size() != 0));
      checkOutput("mon_sticky", 64'(sticky_flags_o), 64'(m_st));
      checkOutput("mon_exc_count", 64'(exc_count_o), CntEn ? 64'(m_cnt) : 64'd0);
      if (sb.size() == 0) begin
        checkOutput("mon_z_o_empty", 64'(z_o), 64'd0);
      end else if (ready_i) begin
        head = sb.pop_front();
        checkOutput("mon_z_o", 64'(z_o), 64'(head[35:4]));
        checkOutput("mon_flags_o", 64'(flags_o), 64'(head[3:0]));
      end
      if (m_yumi) sb.push_back({z_i, flags_i});
      if (clear_flags_i) begin
        m_st  = 4'b0000;
        m_cnt = 2'd0;
      end
      if (m_yumi) begin
        m_st = m_st | flags_i;
        if ((|flags_i) && (m_cnt != 2'd3)) m_cnt = m_cnt + 2'd1;
      end
    end
  end

  typedef struct {
    logic        v;
    logic [31:0] z;
    logic [3:0]  f;
    logic        rdy;
    logic        clr;
    logic        e_yumi;
    logic        e_v;
    logic [31:0] e_z;
    logic [3:0]  e_f;
    logic [3:0]  e_st;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Table: {v, z, flags, ready, clear | yumi before edge | v_o, z_o, flags_o, sticky, count after edge}.
    tbl[0]  = '{1'b1, 32'h40400000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40400000, 4'b0000, 4'b0000, 2'd0};
    tbl[1]  = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0000, 4'b0000, 2'd0};
    tbl[2]  = '{1'b1, 32'h0000000a, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000000a, 4'b1000, 4'b1000, 2'd1};
    tbl[3]  = '{1'b1, 32'h0000000b, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000000a, 4'b1000, 4'b1000, 2'd1};
    tbl[4]  = '{1'b1, 32'h0000000c, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000a, 4'b1000, 4'b1000, 2'd1};
    tbl[5]  = '{1'b1, 32'h0000000c, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000000b, 4'b0000, 4'b1000, 2'd1};
    tbl[6]  = '{1'b1, 32'h0000000c, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000c, 4'b0100, 4'b1100, 2'd2};
    tbl[7]  = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0000, 4'b1100, 2'd2};
    tbl[8]  = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0000, 4'b0000, 2'd0};
    tbl[9]  = '{1'b1, 32'h0000000d, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000d, 4'b0010, 4'b0010, 2'd1};
    tbl[10] = '{1'b1, 32'h0000000e, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000e, 4'b0001, 4'b0011, 2'd2};
    tbl[11] = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0000, 4'b0000, 2'd0};
    tbl[12] = '{1'b1, 32'h0000000f, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000000f, 4'b0100, 4'b0100, 2'd1};
    tbl[13] = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0000, 4'b0100, 2'd1};

    // Reset state, with v_i high to confirm it is ignored.
    reset_i = 1'b1;
    applyStimulus(1'b1, 32'h12345678, 4'b1111, 1'b1, 1'b0);
    #7;
    checkOutput("rst_yumi_o", 64'(yumi_o), 64'd0);
    checkOutput("rst_v_o", 64'(v_o), 64'd0);
    checkOutput("rst_z_o", 64'(z_o), 64'd0);
    checkOutput("rst_flags_o", 64'(flags_o), 64'd0);
    checkOutput("rst_sticky", 64'(sticky_flags_o), 64'd0);
    checkOutput("rst_exc_count", 64'(exc_count_o), 64'd0);
    #6;
    reset_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1;

    // Single op, backpressure ordering and sticky-flag behaviour from the table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].v, tbl[i].z, tbl[i].f, tbl[i].rdy, tbl[i].clr);
      #1;
      checkOutput($sformatf("tbl_yumi_o[%0d]", i), 64'(yumi_o), 64'(tbl[i].e_yumi));
      @(posedge clk_i); #1;
      checkOutput($sformatf("tbl_v_o[%0d]", i), 64'(v_o), 64'(tbl[i].e_v));
      checkOutput($sformatf("tbl_z_o[%0d]", i), 64'(z_o), 64'(tbl[i].e_z));
      checkOutput($sformatf("tbl_flags_o[%0d]", i), 64'(flags_o), 64'(tbl[i].e_f));
      checkOutput($sformatf("tbl_sticky[%0d]", i), 64'(sticky_flags_o), 64'(tbl[i].e_st));
      checkOutput($sformatf("tbl_exc_count[%0d]", i), 64'(exc_count_o),
                  CntEn ? 64'(tbl[i].e_cnt) : 64'd0);
    end

    // Eight streamed ops with ready high: one entry in flight, enq and deq every cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h3f800000 + 32'(k), 4'b0000, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("stream_yumi_o[%0d]", k), 64'(yumi_o), 64'd1);
      @(posedge clk_i); #1;
      checkOutput($sformatf("stream_v_o[%0d]", k), 64'(v_o), 64'd1);
      checkOutput($sformatf("stream_z_o[%0d]", k), 64'(z_o), 64'(32'h3f800000 + 32'(k)));
    end
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    checkOutput("stream_drained_v_o", 64'(v_o), 64'd0);

    // Counter saturation: clear, then five flagged results.
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);
    @(posedge clk_i); #1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h50000000 + 32'(k), 4'b0001, 1'b1, 1'b0);
      @(posedge clk_i); #1;
    end
    checkOutput("sat_exc_count", 64'(exc_count_o), CntEn ? 64'd3 : 64'd0);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);
    @(posedge clk_i); #1;
    checkOutput("sat_cleared_exc_count", 64'(exc_count_o), 64'd0);
    checkOutput("sat_cleared_sticky", 64'(sticky_flags_o), 64'd0);

    // Async reset in the middle of a cycle with the FIFO full.
    applyStimulus(1'b1, 32'haaaa0000, 4'b0010, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    applyStimulus(1'b1, 32'hbbbb0000, 4'b0001, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    checkOutput("full_v_o", 64'(v_o), 64'd1);
    checkOutput("full_sticky", 64'(sticky_flags_o), 64'(4'b0011));
    checkOutput("full_yumi_o", 64'(yumi_o), 64'd0);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("midrst_v_o", 64'(v_o), 64'd0);
    checkOutput("midrst_sticky", 64'(sticky_flags_o), 64'd0);
    checkOutput("midrst_z_o", 64'(z_o), 64'd0);
    checkOutput("midrst_yumi_o", 64'(yumi_o), 64'd0);
    #3;
    reset_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    checkOutput("postrst_v_o", 64'(v_o), 64'd0);

    // Random traffic checked by the monitor, then drain.
    for (int k = 0; k < 120; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      @(posedge clk_i); #1;
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
      @(posedge clk_i); #1;
    end
    checkOutput("final_v_o", 64'(v_o), 64'd0);
    checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
